pic_command_decoder: RTL and testbench

- Write-side front end of the 8259A-compatible PIC.
- Captures CPU bus writes, runs the ICW1→ICW2→[ICW3]→[ICW4] initialization sequence, then decodes operational writes into OCW1, OCW2 and OCW3.
- Drives the OCW1 mask word consumed by the interrupt mask register.
- Drives the mask-read enable (writeIMR) that gates the mask onto the data buffer.

---
 rtl/pic_pkg.sv | 34 +++
 rtl/pic_command_decoder_if.sv | 20 ++
 rtl/pic_bus_strobe.sv | 64 ++++++
 rtl/pic_command_decoder.sv | 171 +++++++++++++++++
 tb/tb_pic_command_decoder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pic_pkg
// Purpose  : Shared types and constants for the 8259A-compatible PIC write-side
//            command decoder: initialization state encoding, control-word bit
//            positions and the mask register reset value.
// Revision : 1.0 - initial release
// ============================================================================
package pic_pkg;

    // Initialization / operational state of the command decoder
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_t;

    // Bit positions inside the command bytes
    localparam int ICW1_SEL = 4;   // a0=0 & D4=1 identifies ICW1
    localparam int OCW3_SEL = 3;   // a0=0 & D4=0: D3 selects OCW3 over OCW2
    localparam int IC4      = 0;   // ICW1: ICW4 will follow
    localparam int SNGL     = 1;   // ICW1: single (non-cascaded) mode
    localparam int LTIM     = 3;   // ICW1: level-triggered mode
    localparam int RIS      = 0;   // OCW3: 1 = read ISR, 0 = read IRR
    localparam int RR       = 1;   // OCW3: RIS is only honoured when RR=1
    localparam int P        = 2;   // OCW3: poll command

    // All IR lines masked out of reset
    localparam logic [7:0] IMR_RESET = 8'hFF;

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_command_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pic_command_decoder_if
// Purpose  : CPU bus seen by the PIC write-side front end.
// Ports    : cs_n, wr_n, rd_n (active-low strobes), a0 (address bit),
//            dataIn[7:0] (CPU write data).
//            master - driven by the CPU side; slave - consumed by the PIC.
// Revision : 1.0 - initial release
// ============================================================================
interface pic_command_decoder_if;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] dataIn;

    modport master (output cs_n, output wr_n, output rd_n, output a0, output dataIn);
    modport slave  (input  cs_n, input  wr_n, input  rd_n, input  a0, input  dataIn);
endinterface : pic_command_decoder_if
`default_nettype wire

// File: rtl/pic_bus_strobe.sv
`default_nettype none
// ============================================================================
// Module   : pic_bus_strobe
// Purpose  : Turns a CPU write strobe of any length into a single commit pulse
//            with the address/data captured while the strobe was low.
// Ports    : clk, reset (sync, active high); cs_n, wr_n, a0, dataIn (bus in);
//            commit (1-cycle, combinational), cmd_a0 / cmd_data (captured).
// Revision : 1.0 - initial release
// ============================================================================
module pic_bus_strobe (
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       cs_n,
    input  wire logic       wr_n,
    input  wire logic       a0,
    input  wire logic [7:0] dataIn,
    output logic            commit,
    output logic            cmd_a0,
    output logic [7:0]      cmd_data
);

    logic       wr_prev_q, wr_prev_d;
    logic       cs_low_q,  cs_low_d;
    logic       a0_q,      a0_d;
    logic [7:0] data_q,    data_d;

    always_comb begin
        wr_prev_d = wr_n;
        cs_low_d  = cs_low_q;
        a0_d      = a0_q;
        data_d    = data_q;
        // cs_n is tracked on every strobe-low cycle so that the chip select
        // seen on the last cycle of the strobe decides whether it commits.
        if (!wr_n) begin
            cs_low_d = ~cs_n;
        end
        if (!wr_n && !cs_n) begin
            a0_d   = a0;
            data_d = dataIn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // wr_prev=1 prevents a strobe released during reset from committing
            wr_prev_q <= 1'b1;
            cs_low_q  <= 1'b0;
            a0_q      <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            wr_prev_q <= wr_prev_d;
            cs_low_q  <= cs_low_d;
            a0_q      <= a0_d;
            data_q    <= data_d;
        end
    end

    // Rising edge of wr_n: exactly one commit per strobe
    assign commit   = ~wr_prev_q & wr_n & cs_low_q;
    assign cmd_a0   = a0_q;
    assign cmd_data = data_q;

endmodule : pic_bus_strobe
`default_nettype wire

// File: rtl/pic_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pic_command_decoder
// Purpose  : Write-side front end of an 8259A-compatible PIC. Runs the
//            ICW1->ICW2->[ICW3]->[ICW4] init sequence, then decodes OCW1/2/3.
// Ports    : clk, reset (sync, active high); bus (CPU bus, slave modport);
//            OCW1, writeIMR, vectorBase, icw3, icw4, ltim, sngl, ocw2,
//            ocw2Valid, readIsr, pollCmd, initDone.
// Revision : 1.0 - initial release
// ============================================================================
module pic_command_decoder #(
    parameter logic [7:0] IMR_RESET = pic_pkg::IMR_RESET
) (
    input  wire logic            clk,
    input  wire logic            reset,
    pic_command_decoder_if.slave bus,
    output logic [7:0]           OCW1,
    output logic                 writeIMR,
    output logic [4:0]           vectorBase,
    output logic [7:0]           icw3,
    output logic [7:0]           icw4,
    output logic                 ltim,
    output logic                 sngl,
    output logic [7:0]           ocw2,
    output logic                 ocw2Valid,
    output logic                 readIsr,
    output logic                 pollCmd,
    output logic                 initDone
);
    import pic_pkg::*;

    logic       commit;
    logic       cmd_a0;
    logic [7:0] cmd_data;

    pic_bus_strobe u_strobe (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (bus.cs_n),
        .wr_n     (bus.wr_n),
        .a0       (bus.a0),
        .dataIn   (bus.dataIn),
        .commit   (commit),
        .cmd_a0   (cmd_a0),
        .cmd_data (cmd_data)
    );

    pic_state_t state_q, state_d;
    logic [7:0] ocw1_q,       ocw1_d;
    logic [4:0] vector_q,     vector_d;
    logic [7:0] icw3_q,       icw3_d;
    logic [7:0] icw4_q,       icw4_d;
    logic       ltim_q,       ltim_d;
    logic       sngl_q,       sngl_d;
    logic       ic4_q,        ic4_d;
    logic [7:0] ocw2_q,       ocw2_d;
    logic       ocw2_valid_q, ocw2_valid_d;
    logic       read_isr_q,   read_isr_d;
    logic       poll_cmd_q,   poll_cmd_d;

    always_comb begin
        state_d      = state_q;
        ocw1_d       = ocw1_q;
        vector_d     = vector_q;
        icw3_d       = icw3_q;
        icw4_d       = icw4_q;
        ltim_d       = ltim_q;
        sngl_d       = sngl_q;
        ic4_d        = ic4_q;
        ocw2_d       = ocw2_q;
        read_isr_d   = read_isr_q;
        ocw2_valid_d = 1'b0;
        poll_cmd_d   = 1'b0;

        if (commit) begin
            if (!cmd_a0 && cmd_data[ICW1_SEL]) begin
                // ICW1 restarts initialization from any state
                ltim_d     = cmd_data[LTIM];
                sngl_d     = cmd_data[SNGL];
                ic4_d      = cmd_data[IC4];
                ocw1_d     = 8'h00;
                read_isr_d = 1'b0;
                icw3_d     = 8'h00;
                icw4_d     = 8'h00;
                state_d    = ST_WAIT_ICW2;
            end else begin
                // Remaining a0=0 writes in the wait states are ignored
                unique case (state_q)
                    ST_WAIT_ICW2: begin
                        if (cmd_a0) begin
                            vector_d = cmd_data[7:3];
                            if (!sngl_q)     state_d = ST_WAIT_ICW3;
                            else if (ic4_q)  state_d = ST_WAIT_ICW4;
                            else             state_d = ST_READY;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        if (cmd_a0) begin
                            icw3_d  = cmd_data;
                            state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        if (cmd_a0) begin
                            icw4_d  = cmd_data;
                            state_d = ST_READY;
                        end
                    end
                    ST_READY: begin
                        if (cmd_a0) begin
                            ocw1_d = cmd_data;
                        end else if (!cmd_data[OCW3_SEL]) begin
                            ocw2_d       = cmd_data;
                            ocw2_valid_d = 1'b1;
                        end else begin
                            if (cmd_data[RR]) read_isr_d = cmd_data[RIS];
                            poll_cmd_d = cmd_data[P];
                        end
                    end
                    default: ;  // IDLE: only ICW1 is accepted
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ocw1_q       <= IMR_RESET;
            vector_q     <= 5'h00;
            icw3_q       <= 8'h00;
            icw4_q       <= 8'h00;
            ltim_q       <= 1'b0;
            sngl_q       <= 1'b0;
            ic4_q        <= 1'b0;
            ocw2_q       <= 8'h00;
            ocw2_valid_q <= 1'b0;
            read_isr_q   <= 1'b0;
            poll_cmd_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ocw1_q       <= ocw1_d;
            vector_q     <= vector_d;
            icw3_q       <= icw3_d;
            icw4_q       <= icw4_d;
            ltim_q       <= ltim_d;
            sngl_q       <= sngl_d;
            ic4_q        <= ic4_d;
            ocw2_q       <= ocw2_d;
            ocw2_valid_q <= ocw2_valid_d;
            read_isr_q   <= read_isr_d;
            poll_cmd_q   <= poll_cmd_d;
        end
    end

    // A concurrent write wins over a mask read, so wr_n low blocks the read
    assign writeIMR   = (state_q == ST_READY) & ~bus.cs_n & ~bus.rd_n & bus.a0 & bus.wr_n;
    assign OCW1       = ocw1_q;
    assign vectorBase = vector_q;
    assign icw3       = icw3_q;
    assign icw4       = icw4_q;
    assign ltim       = ltim_q;
    assign sngl       = sngl_q;
    assign ocw2       = ocw2_q;
    assign ocw2Valid  = ocw2_valid_q;
    assign readIsr    = read_isr_q;
    assign pollCmd    = poll_cmd_q;
    assign initDone   = (state_q == ST_READY);

endmodule : pic_command_decoder
`default_nettype wire

// File: tb/tb_pic_command_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pic_command_decoder
// Purpose  : Directed self-checking bench for pic_command_decoder. Inputs are
//            driven on the falling clock edge, outputs sampled there as well.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pic_command_decoder;

    logic clk;
    logic reset;

    logic [7:0] OCW1;
    logic       writeIMR;
    logic [4:0] vectorBase;
    logic [7:0] icw3;
    logic [7:0] icw4;
    logic       ltim;
    logic       sngl;
    logic [7:0] ocw2;
    logic       ocw2Valid;
    logic       readIsr;
    logic       pollCmd;
    logic       initDone;

    int n_checks;
    int n_pass;

    pic_command_decoder_if bus ();

    pic_command_decoder #(.IMR_RESET(8'hFF)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .OCW1       (OCW1),
        .writeIMR   (writeIMR),
        .vectorBase (vectorBase),
        .icw3       (icw3),
        .icw4       (icw4),
        .ltim       (ltim),
        .sngl       (sngl),
        .ocw2       (ocw2),
        .ocw2Valid  (ocw2Valid),
        .readIsr    (readIsr),
        .pollCmd    (pollCmd),
        .initDone   (initDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One complete write: strobe low for len cycles, then wait through the
    // commit edge and return on the following falling edge.
    task automatic bus_write(input logic a, input logic [7:0] d, input int len);
        @(negedge clk);
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = a; bus.dataIn = d;
        repeat (len - 1) @(negedge clk);
        @(negedge clk);
        bus.wr_n = 1'b1; bus.cs_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.cs_n = 1'b1; bus.wr_n = 1'b1; bus.rd_n = 1'b1;
        bus.a0 = 1'b0; bus.dataIn = 8'h00;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state with a mask read attempted in IDLE
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1;
        #1;
        check("rst_writeIMR", {7'd0, writeIMR}, 8'h00);
        check("rst_OCW1", OCW1, 8'hFF);
        check("rst_initDone", {7'd0, initDone}, 8'h00);
        check("rst_vectorBase", {3'd0, vectorBase}, 8'h00);
        @(negedge clk);
        bus.cs_n = 1'b1; bus.rd_n = 1'b1;

        // IDLE ignores non-ICW1 writes
        bus_write(1'b1, 8'h3C, 1);
        check("idle_ignore_OCW1", OCW1, 8'hFF);

        // Single mode with ICW4: ICW3 skipped
        bus_write(1'b0, 8'h13, 1);
        check("icw1a_OCW1", OCW1, 8'h00);
        check("icw1a_sngl", {7'd0, sngl}, 8'h01);
        bus_write(1'b1, 8'h40, 1);
        check("icw2a_vectorBase", {3'd0, vectorBase}, 8'h08);
        check("icw2a_initDone", {7'd0, initDone}, 8'h00);
        bus_write(1'b1, 8'h01, 1);
        check("icw4a_icw4", icw4, 8'h01);
        check("icw4a_icw3", icw3, 8'h00);
        check("icw4a_initDone", {7'd0, initDone}, 8'h01);

        // Cascade mode with ICW3 and ICW4
        bus_write(1'b0, 8'h11, 1);
        check("icw1b_initDone", {7'd0, initDone}, 8'h00);
        check("icw1b_icw4", icw4, 8'h00);
        bus_write(1'b1, 8'h20, 1);
        check("icw2b_vectorBase", {3'd0, vectorBase}, 8'h04);
        bus_write(1'b0, 8'h08, 1);   // a0=0, D4=0 in wait state: ignored
        check("wait_ignore_icw3", icw3, 8'h00);
        bus_write(1'b1, 8'h04, 1);
        check("icw3b_icw3", icw3, 8'h04);
        check("icw3b_initDone", {7'd0, initDone}, 8'h00);
        bus_write(1'b1, 8'h03, 1);
        check("icw4b_icw4", icw4, 8'h03);
        check("icw4b_initDone", {7'd0, initDone}, 8'h01);

        // OCW1 with a long strobe
        bus_write(1'b1, 8'hA5, 3);
        check("ocw1_long", OCW1, 8'hA5);
        bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1;
        #1;
        check("read_a0_1_writeIMR", {7'd0, writeIMR}, 8'h01);
        bus.a0 = 1'b0;
        #1;
        check("read_a0_0_writeIMR", {7'd0, writeIMR}, 8'h00);
        @(negedge clk);
        bus.cs_n = 1'b1; bus.rd_n = 1'b1;

        // Simultaneous read and write: write wins, no mask read
        @(negedge clk);
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.rd_n = 1'b0; bus.a0 = 1'b1; bus.dataIn = 8'h5A;
        #1;
        check("rdwr_writeIMR", {7'd0, writeIMR}, 8'h00);
        @(negedge clk);
        bus.wr_n = 1'b1; bus.rd_n = 1'b1; bus.cs_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rdwr_OCW1", OCW1, 8'h5A);

        // OCW2 pulse
        bus_write(1'b0, 8'h20, 1);
        check("ocw2_value", ocw2, 8'h20);
        check("ocw2_valid_hi", {7'd0, ocw2Valid}, 8'h01);
        @(negedge clk);
        check("ocw2_valid_lo", {7'd0, ocw2Valid}, 8'h00);

        // OCW3: select ISR, then poll without RR
        bus_write(1'b0, 8'h0B, 1);
        check("ocw3_readIsr", {7'd0, readIsr}, 8'h01);
        check("ocw3_no_poll", {7'd0, pollCmd}, 8'h00);
        bus_write(1'b0, 8'h0C, 1);
        check("ocw3_poll_hi", {7'd0, pollCmd}, 8'h01);
        check("ocw3_readIsr_kept", {7'd0, readIsr}, 8'h01);
        check("ocw3_no_ocw2", {7'd0, ocw2Valid}, 8'h00);
        @(negedge clk);
        check("ocw3_poll_lo", {7'd0, pollCmd}, 8'h00);

        // Re-initialization from READY
        bus_write(1'b0, 8'h1B, 1);
        check("reinit_OCW1", OCW1, 8'h00);
        check("reinit_readIsr", {7'd0, readIsr}, 8'h00);
        check("reinit_ltim", {7'd0, ltim}, 8'h01);
        check("reinit_initDone", {7'd0, initDone}, 8'h00);

        // Reset during a write (an ICW1 that would set sngl if committed)
        @(negedge clk);
        bus.cs_n = 1'b0; bus.wr_n = 1'b0; bus.a0 = 1'b0; bus.dataIn = 8'h13;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.wr_n = 1'b1; bus.cs_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_OCW1", OCW1, 8'hFF);
        check("midrst_sngl", {7'd0, sngl}, 8'h00);
        check("midrst_ltim", {7'd0, ltim}, 8'h00);
        check("midrst_vectorBase", {3'd0, vectorBase}, 8'h00);
        check("midrst_icw3", icw3, 8'h00);
        check("midrst_icw4", icw4, 8'h00);
        check("midrst_ocw2", ocw2, 8'h00);
        check("midrst_initDone", {7'd0, initDone}, 8'h00);
        check("midrst_readIsr", {7'd0, readIsr}, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pic_command_decoder
`default_nettype wire
